bnn_mac_window: RTL and testbench

// Parametrised binary MAC for the BNN datapath. Holds a K_MAX x K_MAX bit window fed one ifmap column per

---
 rtl/bnn_mac_window.sv | 151 +++++++++++++++
 tb/tb_bnn_mac_window.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_mac_window.sv
// Binary MAC over a K_MAX x K_MAX sliding window: XNOR/AND popcount of the active k x k region,
// saturating accumulation across input channels, thresholded result on a valid/ready output.
module bnn_mac_window #(
    parameter int K_MAX = 5,
    parameter int ACC_W = 16,
    parameter int KS_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KS_W-1:0]        cfg_kernel_size,
    input  logic                   cfg_mode,
    input  logic [ACC_W-1:0]       cfg_threshold,
    input  logic                   clear,
    input  logic                   col_valid,
    input  logic [K_MAX-1:0]       col_in,
    input  logic                   wgt_load,
    input  logic [K_MAX*K_MAX-1:0] wgt_in,
    input  logic                   mac_en,
    input  logic                   mac_last,
    output logic                   mac_ready,
    output logic                   mac_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_bit,
    output logic [1:0]             dbg_state
);

    localparam int N      = K_MAX * K_MAX;
    localparam int POP_W  = $clog2(N + 1);
    localparam int FILL_W = $clog2(K_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       win, kern, mask, hits;
    logic [FILL_W-1:0]  fill, k_cfg, k_eff, lat_k;
    logic               mode_eff, lat_mode;
    logic [ACC_W-1:0]   lat_thr, acc, sum_sat;
    logic [ACC_W:0]     sum_ext;
    logic [POP_W-1:0]   pop, pop1;
    logic               last1, act1, accept, full;

    // Output handshake: a result is presented while out_valid is high and is consumed on the
    // rising edge where out_valid & out_ready; out_* hold steady until then.
    assign mac_ready = (state == IDLE) || (state == RUN);
    assign out_valid = (state == HOLD);
    assign dbg_state = state;
    assign accept    = mac_en && mac_ready;

    always_comb begin
        if (cfg_kernel_size == '0 || cfg_kernel_size > KS_W'(K_MAX))
            k_cfg = FILL_W'(K_MAX);
        else
            k_cfg = FILL_W'(cfg_kernel_size);
    end

    // The first beat of a run is taken in IDLE, before the latched copy exists.
    assign k_eff    = (state == IDLE) ? k_cfg : lat_k;
    assign mode_eff = (state == IDLE) ? cfg_mode : lat_mode;
    assign full     = (fill >= k_eff);

    always_comb begin
        mask = '0;
        for (int r = 0; r < K_MAX; r++) begin
            for (int c = 0; c < K_MAX; c++) begin
                if (r < int'(k_eff) && c >= K_MAX - int'(k_eff))
                    mask[r*K_MAX+c] = 1'b1;
            end
        end
    end

    assign hits = (mode_eff ? (win & kern) : ~(win ^ kern)) & mask;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++)
            pop = pop + POP_W'(hits[i]);
    end

    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - POP_W){1'b0}}, pop1};
    assign sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = mac_last ? DRAIN : RUN;
            RUN:     if (accept && mac_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Kernel survives clear; only reset wipes it.
    always_ff @(posedge clk) begin
        if (rst)
            kern <= '0;
        else if (wgt_load)
            kern <= wgt_in;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= IDLE;
            win      <= '0;
            fill     <= '0;
            acc      <= '0;
            pop1     <= '0;
            last1    <= 1'b0;
            act1     <= 1'b0;
            mac_err  <= 1'b0;
            out_sum  <= '0;
            out_bit  <= 1'b0;
            lat_k    <= '0;
            lat_mode <= 1'b0;
            lat_thr  <= '0;
        end else begin
            state <= state_nxt;
            if (col_valid) begin
                for (int r = 0; r < K_MAX; r++) begin
                    for (int c = 0; c < K_MAX - 1; c++)
                        win[r*K_MAX+c] <= win[r*K_MAX+c+1];
                    win[r*K_MAX+K_MAX-1] <= col_in[r];
                end
                if (fill < FILL_W'(K_MAX))
                    fill <= fill + 1'b1;
            end
            if (state == IDLE && accept) begin
                lat_k    <= k_cfg;
                lat_mode <= cfg_mode;
                lat_thr  <= cfg_threshold;
            end
            // A beat taken with a partial window still travels down the pipe so mac_last closes the run.
            act1    <= accept;
            last1   <= accept && mac_last;
            pop1    <= (accept && full) ? pop : '0;
            mac_err <= accept && !full;
            if (act1) begin
                if (last1) begin
                    out_sum <= sum_sat;
                    out_bit <= (sum_sat >= lat_thr);
                    acc     <= '0;
                end else begin
                    acc <= sum_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_mac_window.sv
// Self-checking bench for bnn_mac_window: reference window/kernel model feeding an expected-result
// queue that is drained as the DUT hands results out.
module tb_bnn_mac_window;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_kernel_size;
    logic        cfg_mode;
    logic [15:0] cfg_threshold;
    logic        clear;
    logic        col_valid;
    logic [4:0]  col_in;
    logic        wgt_load;
    logic [24:0] wgt_in;
    logic        mac_en;
    logic        mac_last;
    logic        mac_ready;
    logic        mac_err;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_bit;
    logic [1:0]  dbg_state;

    bnn_mac_window #(.K_MAX(5), .ACC_W(16), .KS_W(5)) dut (
        .clk(clk), .rst(rst),
        .cfg_kernel_size(cfg_kernel_size), .cfg_mode(cfg_mode), .cfg_threshold(cfg_threshold),
        .clear(clear), .col_valid(col_valid), .col_in(col_in),
        .wgt_load(wgt_load), .wgt_in(wgt_in),
        .mac_en(mac_en), .mac_last(mac_last), .mac_ready(mac_ready), .mac_err(mac_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_bit(out_bit),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [16:0] exp_q[$];

    logic [24:0] mw, mk;
    int          m_fill, m_acc, cur_k, cur_thr;
    logic        cur_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pop();
        int p = 0;
        for (int r = 0; r < cur_k; r++) begin
            for (int c = 5 - cur_k; c < 5; c++) begin
                if (cur_mode) p += int'(mw[r*5+c] & mk[r*5+c]);
                else          p += int'(mw[r*5+c] == mk[r*5+c]);
            end
        end
        return p;
    endfunction

    task automatic set_cfg(input int ks, input logic mode, input int thr);
        cfg_kernel_size = ks[4:0];
        cur_k           = (ks == 0 || ks > 5) ? 5 : ks;
        cfg_mode        = mode;
        cur_mode        = mode;
        cfg_threshold   = thr[15:0];
        cur_thr         = thr;
    endtask

    task automatic do_cycle(input logic cv, input logic [4:0] col, input logic wl,
                            input logic [24:0] w, input logic me, input logic last);
        int   p;
        logic e;
        logic b;
        p = 0;
        e = 1'b0;
        if (me) begin
            check("mac_ready_before", mac_ready, 1);
            if (m_fill >= cur_k) p = model_pop();
            else e = 1'b1;
            m_acc += p;
            if (m_acc > 65535) m_acc = 65535;
            if (last) begin
                b = (m_acc >= cur_thr);
                exp_q.push_back({m_acc[15:0], b});
                m_acc = 0;
            end
        end
        col_valid = cv; col_in = col; wgt_load = wl; wgt_in = w; mac_en = me; mac_last = last;
        tick();
        col_valid = 1'b0; wgt_load = 1'b0; mac_en = 1'b0; mac_last = 1'b0;
        check("mac_err", mac_err, e);
        if (cv) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) mw[r*5+c] = mw[r*5+c+1];
                mw[r*5+4] = col[r];
            end
            if (m_fill < 5) m_fill++;
        end
        if (wl) mk = w;
    endtask

    task automatic push_col(input logic [4:0] col);
        do_cycle(1'b1, col, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mw = '0; m_fill = 0; m_acc = 0;
    endtask

    task automatic wait_drain(input logic bp);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick();
        end
        out_ready = 1'b1;
        check("drain_empty", exp_q.size(), 0);
        if (dbg_state == 2'd3) tick();
    endtask

    // Results are taken off the queue on the cycle the DUT hands them over.
    always @(negedge clk) begin
        logic [16:0] v;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                v = exp_q.pop_front();
                check("out_sum", out_sum, v[16:1]);
                check("out_bit", out_bit, v[0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] w;
        logic [4:0]  col;
        logic [16:0] v;
        int          nch;

        rst = 1'b1; clear = 1'b0; col_valid = 1'b0; col_in = '0; wgt_load = 1'b0; wgt_in = '0;
        mac_en = 1'b0; mac_last = 1'b0; out_ready = 1'b1;
        mw = '0; mk = '0; m_fill = 0; m_acc = 0;
        set_cfg(5, 1'b0, 0);
        tick(); tick();
        rst = 1'b0;
        check("rst_mac_ready", mac_ready, 1);
        check("rst_mac_err", mac_err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_state", dbg_state, 0);

        // Single channel, k=3 XNOR, everything ones: 9 matches.
        set_cfg(3, 1'b0, 9);
        do_cycle(1'b0, '0, 1'b1, {25{1'b1}}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_col(5'h1f);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        check("t1_valid_t1", out_valid, 0);
        tick();
        check("t1_valid_t2", out_valid, 1);
        check("t1_sum", out_sum, 9);
        check("t1_bit", out_bit, 1);
        wait_drain(1'b0);
        check("t1_idle", dbg_state, 0);

        // AND mode k=5, alternating kernel, four channels; cfg pins disturbed mid-run.
        set_cfg(5, 1'b1, 60);
        do_cycle(1'b0, '0, 1'b1, 25'h1555555, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) push_col(5'h1f);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        cfg_kernel_size = 5'd2; cfg_mode = 1'b0; cfg_threshold = 16'd0;
        for (int i = 1; i < 4; i++) do_cycle(1'b0, '0, 1'b0, '0, 1'b1, i == 3);
        tick();
        check("t2_sum", out_sum, 52);
        check("t2_bit", out_bit, 0);
        wait_drain(1'b0);

        // Partial window: first beat dropped with an error pulse, kernel kept across clear.
        do_clear();
        set_cfg(3, 1'b0, 5);
        push_col(5'($urandom));
        push_col(5'($urandom));
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        push_col(5'($urandom));
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        wait_drain(1'b0);

        // Backpressure in HOLD: result frozen, new requests ignored.
        set_cfg(4, 1'b0, 10);
        push_col(5'($urandom));
        push_col(5'($urandom));
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        out_ready = 1'b0;
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        tick();
        v = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            check("t4_valid", out_valid, 1);
            check("t4_ready", mac_ready, 0);
            check("t4_sum", out_sum, v[16:1]);
            check("t4_bit", out_bit, v[0]);
            mac_en = 1'b1;
            mac_last = 1'($urandom_range(0, 1));
            tick();
            check("t4_err", mac_err, 0);
        end
        mac_en = 1'b0; mac_last = 1'b0;
        wait_drain(1'b0);
        check("t4_idle", dbg_state, 0);
        check("t4_ready_back", mac_ready, 1);

        // Same-cycle shift and weight load use the old window and kernel; the next beat sees the new ones.
        set_cfg(5, 1'b0, 12);
        for (int i = 0; i < 5; i++) push_col(5'($urandom));
        w = 25'($urandom);
        do_cycle(1'b0, '0, 1'b1, w, 1'b0, 1'b0);
        w = 25'($urandom);
        do_cycle(1'b1, 5'($urandom), 1'b1, w, 1'b1, 1'b1);
        wait_drain(1'b0);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        wait_drain(1'b0);

        // Clear while draining: the in-flight result is dropped.
        set_cfg(5, 1'b0, 0);
        for (int i = 0; i < 5; i++) push_col(5'($urandom));
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        check("t6_drain", dbg_state, 2);
        void'(exp_q.pop_back());
        do_clear();
        for (int i = 0; i < 4; i++) begin
            check("t6_no_valid", out_valid, 0);
            tick();
        end
        check("t6_idle", dbg_state, 0);
        for (int i = 0; i < 5; i++) push_col(5'($urandom));
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        wait_drain(1'b0);

        // Random runs: kernel sizes including out-of-range, both modes, shifting during MACs, backpressure.
        for (int t = 0; t < 25; t++) begin
            set_cfg($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 50));
            do_cycle(1'b0, '0, 1'b1, 25'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) push_col(5'($urandom));
            nch = $urandom_range(1, 4);
            for (int j = 0; j < nch; j++) begin
                col = 5'($urandom);
                do_cycle(1'($urandom_range(0, 1)), col, 1'b0, '0, 1'b1, j == nch - 1);
            end
            wait_drain(1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
